power_emu_sequencer: RTL and testbench

Sequencer that sits between the power-emulator register interface and the `TOP` compute engine. It queues run requests, drives one `start` pulse per run, waits for `fin`, and captures each result into a small result FIFO for software readback. Status flags report busy, overflow and timeout. An optional watchdog bounds the wait per run.

---
 rtl/power_emu_pkg.sv | 30 +++
 rtl/power_emu_result_fifo.sv | 72 +++++++
 rtl/power_emu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_power_emu_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_emu_pkg.sv
// power_emu_pkg: shared types and constants for the power-emulator sequencer.
// Holds the sequencer state encoding, status bit positions, the pending-run
// ceiling and the default result-width helper.
package power_emu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Bit positions inside the 16-bit status word.
  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_MSB = 2;
  localparam int STAT_BUSY      = 3;
  localparam int STAT_OVERFLOW  = 4;
  localparam int STAT_TIMEOUT   = 5;
  localparam int STAT_PEND_LSB  = 6;
  localparam int STAT_PEND_MSB  = 9;

  // The pending counter is 4 bits wide, so 15 outstanding runs is the ceiling.
  localparam int PENDING_MAX = 15;

  // An accumulated engine result needs BITS plus enough headroom for CGES stages.
  function automatic int res_w_default(input int bits, input int cges);
    return $clog2(cges) + bits;
  endfunction

endpackage

// File: rtl/power_emu_result_fifo.sv
// power_emu_result_fifo: small result FIFO with a registered head word.
// rd side is first-word-fall-through: head holds the oldest entry (0 when
// empty) and moves to the next entry on the edge that accepts a pop.
// A pop on an empty FIFO is ignored. When full, a push is accepted only if a
// pop is accepted in the same cycle (the pop is applied first).
module power_emu_result_fifo #(
  parameter int RES_W      = 36,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int PW        = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [RES_W-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count,
  output logic [RES_W-1:0] head
);

  logic [RES_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_n;
  logic [PW-1:0]    count_after_pop;
  logic [RES_W-1:0] head_n;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == PW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next head word: oldest surviving entry, or the word being pushed into an
  // otherwise empty FIFO, or 0 when nothing remains.
  always_comb begin
    rd_ptr_n        = rd_ptr + PW'(do_pop);
    count_after_pop = count - PW'(do_pop);
    head_n          = '0;
    if (count_after_pop != '0) begin
      head_n = mem[rd_ptr_n[AW-1:0]];
    end else if (do_push) begin
      head_n = push_data;
    end
  end

  // Storage array; contents need no reset because head and count gate them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer and registered head update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr_n;
      head   <= head_n;
    end
  end

endmodule

// File: rtl/power_emu_sequencer.sv
// power_emu_sequencer: queues engine run requests, pulses eng_start once per
// run, waits for eng_fin and captures each result into a readback FIFO.
// Optional watchdog: define POWER_EMU_TIMEOUT_EN to bound each WAIT to
// TIMEOUT_CYC cycles; without it WAIT ends only on eng_fin or abort.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready does not depend on cmd_valid. rd_valid
// mirrors FIFO non-empty and rd_pop is a consume strobe that is ignored while
// rd_valid is low.
module power_emu_sequencer
  import power_emu_pkg::*;
#(
  parameter int RES_W       = res_w_default(32, 13),
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             abort,
  input  logic             clr_status,
  output logic             eng_start,
  input  logic             eng_fin,
  input  logic [RES_W-1:0] eng_result,
  input  logic             rd_pop,
  output logic             rd_valid,
  output logic [RES_W-1:0] rd_data,
  output logic [15:0]      status
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t    state;
  seq_state_t    state_n;
  logic [3:0]    pending;
  logic          accept;
  logic          capture;
  logic          expire;
  logic          run_done;
  logic          ovf_q;
  logic          ovf_set;
  logic          tmo_q;
  logic          busy;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW-1:0] fifo_count;

  assign cmd_ready = !abort && (pending < 4'(PENDING_MAX));
  assign accept    = cmd_valid && cmd_ready;
  // eng_fin only counts while waiting, and abort suppresses it.
  assign capture   = !abort && (state == WAIT) && eng_fin;
  // A full FIFO drops the result unless software frees a slot in the same cycle.
  assign ovf_set   = capture && fifo_full && !rd_pop;
  assign run_done  = capture || expire;

`ifdef POWER_EMU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_cnt;

  // eng_fin in the expiry cycle takes precedence over the watchdog.
  assign expire = !abort && (state == WAIT) && !eng_fin &&
                  (wd_cnt == TW'(TIMEOUT_CYC - 1));

  // Watchdog counts WAIT cycles and is held at zero everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (abort || (state != WAIT)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + TW'(1);
    end
  end

  // Sticky timeout flag; a same-cycle expiry beats clr_status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= 1'b0;
    end else if (expire) begin
      tmo_q <= 1'b1;
    end else if (clr_status) begin
      tmo_q <= 1'b0;
    end
  end
`else
  logic tmo_unused;

  assign expire     = 1'b0;
  assign tmo_q      = 1'b0;
  assign tmo_unused = (TIMEOUT_CYC == 0);
`endif

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pending != 4'd0) state_n = START;
      START:   state_n = WAIT;
      WAIT:    if (eng_fin || expire) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
    end
  end

  // State register and the start strobe, which trails START by one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      eng_start <= 1'b0;
    end else begin
      state     <= state_n;
      eng_start <= (state == START);
    end
  end

  // Outstanding-run counter; accept and completion together cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 4'd0;
    end else if (abort) begin
      pending <= 4'd0;
    end else begin
      case ({accept, run_done})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  // Sticky overflow flag; a same-cycle drop beats clr_status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (clr_status) begin
      ovf_q <= 1'b0;
    end
  end

  power_emu_result_fifo #(
    .RES_W      (RES_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (eng_result),
    .pop       (rd_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (rd_data)
  );

  assign rd_valid = !fifo_empty;
  assign busy     = (state != IDLE) || (pending != 4'd0);

  // Status word assembly; unused upper bits stay zero.
  always_comb begin
    status = '0;
    status[STAT_COUNT_MSB:STAT_COUNT_LSB] = 3'(fifo_count);
    status[STAT_BUSY]                     = busy;
    status[STAT_OVERFLOW]                 = ovf_q;
    status[STAT_TIMEOUT]                  = tmo_q;
    status[STAT_PEND_MSB:STAT_PEND_LSB]   = pending;
  end

endmodule

// File: tb/tb_power_emu_sequencer.sv
// tb_power_emu_sequencer: directed sequences, an overflow vector table and a
// randomized run against a queue-based reference model of the sequencer.
module tb_power_emu_sequencer;

  localparam int RES_W       = 36;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             abort;
  logic             clr_status;
  logic             eng_start;
  logic             eng_fin;
  logic [RES_W-1:0] eng_result;
  logic             rd_pop;
  logic             rd_valid;
  logic [RES_W-1:0] rd_data;
  logic [15:0]      status;

  int errors    = 0;
  int checks    = 0;
  int edge_cnt  = 0;
  int start_cnt = 0;
  int n;

  typedef struct {
    logic             clr_before;
    logic             pop_at_fin;
    logic [RES_W-1:0] result;
    logic [2:0]       exp_count;
    logic             exp_ovf;
    logic [RES_W-1:0] exp_head;
  } vec_t;

  vec_t vecs[6];

  // Reference model state for the randomized phase.
  logic [RES_W-1:0] m_q[$];
  int               m_pend;
  bit               m_ovf;
  bit               m_running;
  int               m_start_edge;
  int               m_fin_edge;
  int               m_idle_edge;
  logic [RES_W-1:0] m_res;

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  power_emu_sequencer #(
    .RES_W       (RES_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .clr_status (clr_status),
    .eng_start  (eng_start),
    .eng_fin    (eng_fin),
    .eng_result (eng_result),
    .rd_pop     (rd_pop),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .status     (status)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
    if (eng_start) start_cnt++;
  endtask

  task automatic do_reset();
    cmd_valid  = 1'b0;
    abort      = 1'b0;
    clr_status = 1'b0;
    eng_fin    = 1'b0;
    eng_result = '0;
    rd_pop     = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    edge_cnt = 0;
  endtask

  task automatic issue_cmd();
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int cyc);
    cyc = 0;
    while (!eng_start && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("start_seen", 64'(eng_start), 64'd1);
  endtask

  // eng_start is high now; return the result d edges later.
  task automatic run_engine(input logic [RES_W-1:0] r, input int d);
    repeat (d - 1) tick();
    eng_fin    = 1'b1;
    eng_result = r;
    tick();
    eng_fin    = 1'b0;
  endtask

  function automatic logic [RES_W-1:0] rand36();
    return {4'($urandom_range(0, 15)), 32'($urandom())};
  endfunction

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 36'hA_0000_0001, 3'd1, 1'b0, 36'hA_0000_0001};
    vecs[1] = '{1'b0, 1'b0, 36'hA_0000_0002, 3'd2, 1'b0, 36'hA_0000_0001};
    vecs[2] = '{1'b0, 1'b0, 36'hA_0000_0003, 3'd3, 1'b0, 36'hA_0000_0001};
    vecs[3] = '{1'b0, 1'b0, 36'hA_0000_0004, 3'd4, 1'b0, 36'hA_0000_0001};
    vecs[4] = '{1'b0, 1'b0, 36'hA_0000_0005, 3'd4, 1'b1, 36'hA_0000_0001};
    vecs[5] = '{1'b1, 1'b1, 36'hA_0000_0006, 3'd4, 1'b0, 36'hA_0000_0002};

    // ---------------- reset values ----------------
    do_reset();
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // ---------------- single run ----------------
    start_cnt = 0;
    issue_cmd();
    chk("lat_e0", 64'(eng_start), 64'd0);
    chk("lat_pend1", 64'(status[9:6]), 64'd1);
    tick();
    chk("lat_e1", 64'(eng_start), 64'd0);
    tick();
    chk("lat_e2", 64'(eng_start), 64'd1);
    run_engine(36'h9_1234_5678, 10);
    chk("single_rd_valid", 64'(rd_valid), 64'd1);
    chk("single_rd_data", 64'(rd_data), 64'h9_1234_5678);
    chk("single_pend0", 64'(status[9:6]), 64'd0);
    chk("single_busy_done", 64'(status[3]), 64'd1);
    tick();
    chk("single_status_idle", 64'(status), 64'h0001);
    chk("single_one_start", 64'(start_cnt), 64'd1);
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    chk("single_popped", 64'(rd_valid), 64'd0);

    // ---------------- queue of three ----------------
    cmd_valid = 1'b1;
    repeat (3) tick();
    cmd_valid = 1'b0;
    chk("queue_pend3", 64'(status[9:6]), 64'd3);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin
        wait_start(20, n);
        chk("queue_gap", 64'(n), 64'd3);
      end
      run_engine(36'(k), 2);
      chk("queue_pend", 64'(status[9:6]), 64'(3 - k));
    end
    for (int k = 1; k <= 3; k++) begin
      chk("queue_pop_data", 64'(rd_data), 64'(k));
      rd_pop = 1'b1;
      tick();
      rd_pop = 1'b0;
    end
    chk("queue_empty_valid", 64'(rd_valid), 64'd0);
    chk("queue_empty_data", 64'(rd_data), 64'd0);

    // ---------------- overflow vector table ----------------
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].clr_before) begin
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("ovf_cleared", 64'(status[4]), 64'd0);
      end
      issue_cmd();
      wait_start(20, n);
      repeat (2) tick();
      eng_fin    = 1'b1;
      eng_result = vecs[i].result;
      rd_pop     = vecs[i].pop_at_fin;
      tick();
      eng_fin    = 1'b0;
      rd_pop     = 1'b0;
      chk("vec_count", 64'(status[2:0]), 64'(vecs[i].exp_count));
      chk("vec_ovf", 64'(status[4]), 64'(vecs[i].exp_ovf));
      chk("vec_head", 64'(rd_data), 64'(vecs[i].exp_head));
      tick();
    end
    rd_pop = 1'b1;
    repeat (4) tick();
    rd_pop = 1'b0;
    chk("vec_drained", 64'(rd_valid), 64'd0);

    // ---------------- abort in WAIT with simultaneous fin ----------------
    cmd_valid = 1'b1;
    repeat (2) tick();
    cmd_valid = 1'b0;
    wait_start(10, n);
    chk("abort_pend2", 64'(status[9:6]), 64'd2);
    abort      = 1'b1;
    eng_fin    = 1'b1;
    eng_result = 36'h0_0000_DEAD;
    cmd_valid  = 1'b1;
    #1;
    chk("abort_ready_low", 64'(cmd_ready), 64'd0);
    tick();
    abort     = 1'b0;
    eng_fin   = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_status", 64'(status), 64'd0);
    chk("abort_no_write", 64'(rd_valid), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_no_start", 64'(eng_start), 64'd0);
    end

    // ---------------- watchdog ----------------
`ifdef POWER_EMU_TIMEOUT_EN
    issue_cmd();
    wait_start(20, n);
    repeat (7) tick();
    chk("tmo_not_yet", 64'(status[5]), 64'd0);
    tick();
    chk("tmo_set", 64'(status[5]), 64'd1);
    chk("tmo_pend0", 64'(status[9:6]), 64'd0);
    chk("tmo_fifo_empty", 64'(status[2:0]), 64'd0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("tmo_cleared", 64'(status[5]), 64'd0);
`else
    issue_cmd();
    wait_start(20, n);
    repeat (100) tick();
    chk("notmo_busy", 64'(status[3]), 64'd1);
    chk("notmo_pend1", 64'(status[9:6]), 64'd1);
    chk("notmo_flag", 64'(status[5]), 64'd0);
    eng_fin    = 1'b1;
    eng_result = 36'h7_0000_0777;
    tick();
    eng_fin    = 1'b0;
    chk("notmo_late_valid", 64'(rd_valid), 64'd1);
    chk("notmo_late_data", 64'(rd_data), 64'h7_0000_0777);
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
`endif

    // ---------------- async reset mid-WAIT ----------------
    repeat (2) tick();
    issue_cmd();
    wait_start(20, n);
    run_engine(36'h5_5555_AAAA, 1);
    issue_cmd();
    wait_start(20, n);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    chk("arst_status", 64'(status), 64'd0);
    chk("arst_eng_start", 64'(eng_start), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    edge_cnt = 0;
    issue_cmd();
    tick();
    chk("arst_restart_e1", 64'(eng_start), 64'd0);
    tick();
    chk("arst_restart_e2", 64'(eng_start), 64'd1);

    // ---------------- randomized run against reference model ----------------
    do_reset();
    m_q.delete();
    m_pend       = 0;
    m_ovf        = 1'b0;
    m_running    = 1'b0;
    m_start_edge = 0;
    m_fin_edge   = 0;
    m_idle_edge  = 0;
    m_res        = '0;
    for (int c = 0; c < 3000; c++) begin
      int  e;
      bit  in_wait;
      bit  accept;
      bit  cap;
      bit  ovf_set;
      bit  busy_exp;
      e          = edge_cnt + 1;
      cmd_valid  = ($urandom_range(0, 99) < 35);
      rd_pop     = ($urandom_range(0, 99) < 25);
      clr_status = ($urandom_range(0, 99) < 4);
      in_wait    = m_running && (e >= m_start_edge + 1);
      if (in_wait && e == m_fin_edge) begin
        eng_fin    = 1'b1;
        eng_result = m_res;
      end else if (!in_wait && $urandom_range(0, 9) == 0) begin
        eng_fin    = 1'b1;
        eng_result = rand36();
      end else begin
        eng_fin = 1'b0;
      end
      chk("rnd_cmd_ready", 64'(cmd_ready), 64'(m_pend < 15));
      tick();

      accept  = cmd_valid && (m_pend < 15);
      cap     = in_wait && eng_fin;
      ovf_set = 1'b0;
      if (rd_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (cap) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(eng_result);
        else ovf_set = 1'b1;
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (clr_status) m_ovf = 1'b0;
      m_pend = m_pend + int'(accept) - int'(cap);
      if (cap) begin
        m_running   = 1'b0;
        m_idle_edge = edge_cnt + 1;
      end
      if (!m_running && m_pend > 0 && edge_cnt >= m_idle_edge) begin
        m_running    = 1'b1;
        m_start_edge = edge_cnt + 2;
        m_fin_edge   = m_start_edge + $urandom_range(1, 6);
        m_res        = rand36();
      end
      busy_exp = (m_pend != 0) || m_running || (edge_cnt < m_idle_edge);

      chk("rnd_eng_start", 64'(eng_start), 64'(m_running && edge_cnt == m_start_edge));
      chk("rnd_rd_valid", 64'(rd_valid), 64'(m_q.size() > 0));
      chk("rnd_rd_data", 64'(rd_data), (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
      chk("rnd_status", 64'(status),
          64'({6'b0, 4'(m_pend), 1'b0, m_ovf, busy_exp, 3'(m_q.size())}));
    end
    cmd_valid  = 1'b0;
    rd_pop     = 1'b0;
    clr_status = 1'b0;
    eng_fin    = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
